// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Optional checksum/ack feature is enabled by defining UART_LOADER_CHECKSUM_EN.
package uart_boot_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 2;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned CSUM_W         = 16;

  typedef enum logic [1:0] {
    SAMPLE = 2'd0,
    LOAD   = 2'd1,
    ACK    = 2'd2,
    BOOT   = 2'd3
  } state_e;

  // Sub-phases of the checksum transmit sequence in ACK.
  typedef enum logic [1:0] {
    TX_SEND    = 2'd0,
    TX_WAIT_HI = 2'd1,
    TX_WAIT_LO = 2'd2
  } tx_phase_e;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Byte-in / word-out bus between UART receiver, boot loader and RAM write port.
//   rx_valid, rx_data            : received byte strobe and data
//   ram_wr_en, ram_addr, ram_wdata: RAM word write port
// master = boot loader side, slave = SoC (UART rx + RAM) side.
interface uart_boot_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  modport master (
    input  rx_valid, rx_data,
    output ram_wr_en, ram_addr, ram_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  ram_wr_en, ram_addr, ram_wdata
  );
endinterface

// File: rtl/uart_boot_loader_packer.sv
// Packs bytes little-endian into 32-bit words.
//   in_valid/in_data : accepted byte
//   lane             : lane the next byte lands in
//   word_valid       : one-cycle strobe, the cycle after the 4th byte
//   word_data        : completed word, held until the next completion
module uart_byte_packer
  import uart_boot_pkg::*;
(
  input  logic              clk,
  input  logic              rstb,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic [LANE_W-1:0] lane,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [WORD_W-1:0] word_q;

  // Assembly buffer is separate from word_data so a byte arriving in the
  // write cycle cannot disturb the word being written.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lane       <= '0;
      word_q     <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (in_valid) begin
        word_q[{lane, 3'b000} +: 8] <= in_data;
        lane <= lane + LANE_W'(1);
        if (lane == LANE_W'(BYTES_PER_WORD - 1)) begin
          word_valid <= 1'b1;
          word_data  <= {in_data, word_q[23:0]};
        end
      end
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: when sw_uart_upgrade_b is low at reset release, holds the
// CPU in reset, writes RAM_SIZE received bytes as words from address 0, then
// releases the CPU. Otherwise boots immediately.
// Ports: clk, rstb (async active-low), sw_uart_upgrade_b, bus (rx byte in,
// RAM word write out), cpu_rstb, loading, load_done.
// With UART_LOADER_CHECKSUM_EN: csum, tx_valid, tx_data out; tx_busy in.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int unsigned RAM_SIZE = 16'h4000,
  parameter int unsigned ADDR_W   = 12
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                sw_uart_upgrade_b,
  uart_boot_loader_if.master  bus,
  output logic                cpu_rstb,
  output logic                loading,
  output logic                load_done
`ifdef UART_LOADER_CHECKSUM_EN
  ,
  output logic [CSUM_W-1:0]   csum,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_busy
`endif
);

  localparam int unsigned CNT_W = $clog2(RAM_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAM_SIZE);

  state_e              state_q, state_d;
  logic                cpu_rstb_d, loading_d, load_done_d;
  logic [CNT_W-1:0]    byte_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LANE_W-1:0]   lane;
  logic                word_valid;
  logic [WORD_W-1:0]   word_data;
  logic                accept;

  // Bytes past the last one are dropped, which also covers the BOOT entry cycle.
  assign accept = bus.rx_valid && (state_q == LOAD) && (byte_cnt_q != CNT_FULL);

  uart_byte_packer u_packer (
    .clk        (clk),
    .rstb       (rstb),
    .in_valid   (accept),
    .in_data    (bus.rx_data),
    .lane       (lane),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  assign bus.ram_wr_en = word_valid;
  assign bus.ram_wdata = word_data;
  assign bus.ram_addr  = addr_q;

  // Byte counter and write address; address is the index of the word being completed.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      byte_cnt_q <= '0;
      addr_q     <= '0;
    end else if (accept) begin
      byte_cnt_q <= byte_cnt_q + CNT_W'(1);
      if (lane == LANE_W'(BYTES_PER_WORD - 1)) begin
        addr_q <= ADDR_W'(byte_cnt_q >> 2);
      end
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  tx_phase_e tx_phase_q, tx_phase_d;
  logic      tx_idx_q, tx_idx_d;
  logic      tx_valid_d;
  logic [7:0] tx_data_d;

  // Running checksum of accepted bytes.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) csum <= '0;
    else if (accept) csum <= csum + CSUM_W'(bus.rx_data);
  end
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= SAMPLE;
      cpu_rstb  <= 1'b0;
      loading   <= 1'b0;
      load_done <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      tx_phase_q <= TX_SEND;
      tx_idx_q   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cpu_rstb  <= cpu_rstb_d;
      loading   <= loading_d;
      load_done <= load_done_d;
`ifdef UART_LOADER_CHECKSUM_EN
      tx_phase_q <= tx_phase_d;
      tx_idx_q   <= tx_idx_d;
      tx_valid   <= tx_valid_d;
      tx_data    <= tx_data_d;
`endif
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    cpu_rstb_d  = cpu_rstb;
    loading_d   = loading;
    load_done_d = load_done;
`ifdef UART_LOADER_CHECKSUM_EN
    tx_phase_d  = tx_phase_q;
    tx_idx_d    = tx_idx_q;
    tx_valid_d  = 1'b0;
    tx_data_d   = tx_data;
`endif
    case (state_q)
      SAMPLE: begin
        if (!sw_uart_upgrade_b) begin
          state_d   = LOAD;
          loading_d = 1'b1;
        end else begin
          state_d    = BOOT;
          cpu_rstb_d = 1'b1;
        end
      end
      LOAD: begin
        if (word_valid && (byte_cnt_q == CNT_FULL)) begin
          loading_d   = 1'b0;
          load_done_d = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
          state_d     = ACK;
`else
          state_d     = BOOT;
          cpu_rstb_d  = 1'b1;
`endif
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      // Send csum low byte then high byte, each gated on a full busy pulse.
      ACK: begin
        case (tx_phase_q)
          TX_SEND: begin
            if (!tx_busy) begin
              tx_valid_d = 1'b1;
              tx_data_d  = tx_idx_q ? csum[15:8] : csum[7:0];
              tx_phase_d = TX_WAIT_HI;
            end
          end
          TX_WAIT_HI: if (tx_busy) tx_phase_d = TX_WAIT_LO;
          TX_WAIT_LO: begin
            if (!tx_busy) begin
              if (tx_idx_q) begin
                state_d    = BOOT;
                cpu_rstb_d = 1'b1;
              end else begin
                tx_idx_d   = 1'b1;
                tx_phase_d = TX_SEND;
              end
            end
          end
          default: tx_phase_d = TX_SEND;
        endcase
      end
`endif
      BOOT: begin
        state_d = BOOT;
      end
      default: state_d = SAMPLE;
    endcase
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  localparam int unsigned RAM_SIZE = 16;
  localparam int unsigned ADDR_W   = 4;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rstb;
  logic sw_b;
  logic cpu_rstb, loading, load_done;
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;

  uart_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef UART_LOADER_CHECKSUM_EN
  logic [15:0] csum;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_busy;
  int          busy_cnt = 0;
  logic [7:0]  tx_log[$];
`endif

  uart_boot_loader #(.RAM_SIZE(RAM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .rstb              (rstb),
    .sw_uart_upgrade_b (sw_b),
    .bus               (bus),
    .cpu_rstb          (cpu_rstb),
    .loading           (loading),
    .load_done         (load_done)
`ifdef UART_LOADER_CHECKSUM_EN
    ,
    .csum              (csum),
    .tx_valid          (tx_valid),
    .tx_data           (tx_data),
    .tx_busy           (tx_busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef UART_LOADER_CHECKSUM_EN
  // Simple UART transmitter: busy for a few cycles after each tx_valid.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (tx_valid === 1'b1) begin
      tx_log.push_back(tx_data);
      busy_cnt <= 4;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
`endif

  // Observed RAM writes.
  wr_t got_q[$];
  always @(negedge clk) begin
    if (bus.ram_wr_en === 1'b1) got_q.push_back('{int'(bus.ram_addr), bus.ram_wdata, cyc});
  end

  // Reference model: mode latched at reset, bytes accepted while count < RAM_SIZE.
  bit          m_load;
  int unsigned m_cnt;
  int unsigned m_sum;
  logic [7:0]  m_bytes[$];
  wr_t         exp_q[$];

  task automatic model_reset(input logic sw);
    m_load = !sw;
    m_cnt  = 0;
    m_sum  = 0;
    m_bytes.delete();
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_load && m_cnt < RAM_SIZE) begin
      m_bytes.push_back(b);
      m_cnt++;
      m_sum += b;
      if (m_cnt % 4 == 0)
        exp_q.push_back('{m_cnt / 4 - 1,
                          {m_bytes[m_cnt-1], m_bytes[m_cnt-2], m_bytes[m_cnt-3], m_bytes[m_cnt-4]},
                          cyc + 1});
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    model_byte(b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
      chk({tag, "_data"}, got_q[i].data, exp_q[i].data);
      chk({tag, "_cycle"}, got_q[i].cyc, exp_q[i].cyc);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input logic sw);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    sw_b = sw;
    rstb = 1'b0;
    model_reset(sw);
`ifdef UART_LOADER_CHECKSUM_EN
    tx_log.delete();
`endif
    #1;
    chk("rst_wr_en", bus.ram_wr_en, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_cpu_rstb", cpu_rstb, 0);
    chk("rst_loading", loading, 0);
    chk("rst_load_done", load_done, 0);
    idle(2);
    rstb = 1'b1;
    got_q.delete();
    if (!sw) begin
      idle(1);
      chk("upg_loading", loading, 1);
      chk("upg_cpu_held", cpu_rstb, 0);
    end else begin
      idle(2);
      chk("boot_cpu_rstb", cpu_rstb, 1);
      chk("boot_loading", loading, 0);
      chk("boot_load_done", load_done, 0);
    end
  endtask

  task automatic wait_boot(input string tag);
    int n = 0;
    while (cpu_rstb !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
    chk({tag, "_boot_in_time"}, (n < 300), 1);
    chk({tag, "_load_done"}, load_done, 1);
    chk({tag, "_loading_off"}, loading, 0);
`ifdef UART_LOADER_CHECKSUM_EN
    chk({tag, "_csum"}, csum, 16'(m_sum));
    chk({tag, "_tx_count"}, tx_log.size(), 2);
    chk({tag, "_tx_lo"}, (tx_log.size() > 0) ? tx_log[0] : 8'hxx, m_sum[7:0]);
    chk({tag, "_tx_hi"}, (tx_log.size() > 1) ? tx_log[1] : 8'hxx, m_sum[15:8]);
    chk({tag, "_tx_idle"}, tx_busy, 0);
`endif
  endtask

  task automatic extra_bytes(input string tag);
    logic [ADDR_W-1:0] a;
    a = bus.ram_addr;
    for (int i = 0; i < 5; i++) send(8'($urandom), $urandom_range(0, 2));
    idle(3);
    chk({tag, "_no_writes"}, got_q.size(), 0);
    chk({tag, "_addr_held"}, bus.ram_addr, a);
    chk({tag, "_cpu_stays"}, cpu_rstb, 1);
    got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Normal boot: switch inactive, no writes.
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) send(8'($urandom), 1);
    idle(3);
    chk("boot_no_writes", got_q.size(), 0);
    chk("boot_no_done", load_done, 0);
    sw_b = 1'b0;
    idle(2);
    chk("boot_mode_latched", cpu_rstb, 1);

    // Upgrade load of 00..0F with a UART-like gap.
    do_reset(1'b0);
    sw_b = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), 6);
    wait_boot("seq");
    chk("seq_w1_data", (got_q.size() > 1) ? got_q[1].data : 32'hx, 32'h07060504);
    check_writes("seq");
    chk("seq_last_addr", bus.ram_addr, 3);
    extra_bytes("seq_extra");

    // Back-to-back bytes, EE left waiting in lane 0.
    do_reset(1'b0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0); send(8'hEE, 0);
    idle(3);
    chk("b2b_word", (got_q.size() > 0) ? got_q[0].data : 32'hx, 32'hDDCCBBAA);
    check_writes("b2b_first");
    send(8'($urandom), 0); send(8'($urandom), 0);
    idle(3);
    chk("b2b_partial_no_write", got_q.size(), 0);
    send(8'($urandom), 0);
    for (int i = 0; i < 8; i++) send(8'($urandom), $urandom_range(0, 3));
    wait_boot("b2b");
    check_writes("b2b_rest");

    // Reset mid-load, then a clean reload of 10..1F.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) send(8'($urandom_range(1, 255)), $urandom_range(0, 2));
    idle(2);
    check_writes("partial");
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), $urandom_range(0, 4));
    wait_boot("reload");
    chk("reload_w0_data", (got_q.size() > 0) ? got_q[0].data : 32'hx, 32'h13121110);
    check_writes("reload");
    extra_bytes("reload_extra");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits inside the SoC between the UART receiver and the instruction/data RAM write port.
- When the upgrade switch is active (sw_uart_upgrade_b low at reset release):
  - holds the CPU in reset;
  - packs incoming UART bytes little-endian into 32-bit words;
  - writes the words to RAM from address 0 up to RAM_SIZE bytes;
  - then releases the CPU.
- When the upgrade switch is inactive, the block passes straight through to boot with the CPU out of reset.

Parameters:
- RAM_SIZE, 16'h4000, RAM size in bytes (multiple of 4); total bytes accepted per load.
- ADDR_W, 12, word-address width; must satisfy 2**ADDR_W >= RAM_SIZE/4.

Ports:
- clk  in  1  system clock.
- rstb  in  1  asynchronous active-low reset.
- sw_uart_upgrade_b  in  1  upgrade switch, active low; sampled on the first clk after rstb deasserts.
- rx_valid  in  1  one-cycle strobe from UART receiver; rx_data valid this cycle.
- rx_data  in  8  received byte.
- ram_wr_en  out  1  one-cycle RAM word write strobe.
- ram_addr  out  ADDR_W  word address for the write.
- ram_wdata  out  32  write data; first received byte in [7:0].
- cpu_rstb  out  1  active-low reset to the CPU core.
- loading  out  1  high while in LOAD.
- load_done  out  1  high once RAM_SIZE bytes have been written; stays high until reset.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rstb is asynchronous active-low.
  - Reset values: ram_wr_en=0, ram_addr=0, ram_wdata=0, cpu_rstb=0, loading=0, load_done=0.
  - Internal reset values: byte counter 0, byte lane 0, state SAMPLE.
- FSM states: SAMPLE, LOAD, BOOT.
  - SAMPLE (exactly one cycle after reset release):
    - sw_uart_upgrade_b=0 -> LOAD, with loading=1.
    - sw_uart_upgrade_b=1 -> BOOT.
  - LOAD:
    - On each rx_valid: shift rx_data into byte lane [lane*8+7:lane*8] of the word buffer, lane increments mod 4, byte_cnt increments.
    - When the 4th byte of a word is accepted (lane 3), the next cycle asserts ram_wr_en for exactly 1 cycle with the completed word.
    - ram_addr equals the word index (byte_cnt_at_write/4). ram_addr is held after the write and advances by 1 after each write.
    - Latency: rx_valid of byte 3 at cycle N -> ram_wr_en at cycle N+1.
    - When the write of the final word (byte RAM_SIZE-1) is issued -> BOOT on the following cycle.
  - BOOT:
    - cpu_rstb=1, loading=0.
    - load_done=1 only if BOOT was entered from LOAD.
    - All further rx_valid are ignored; no RAM writes.
- Mode latch: sw_uart_upgrade_b changes after SAMPLE are ignored until the next reset.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss. The word buffer is double-registered from the write output, so the byte arriving in cycle N+1 does not corrupt ram_wdata.
- Reset mid-load: everything returns to reset values. The partial word is discarded and a new load restarts at address 0.
- cpu_rstb is a registered output and must be glitch-free.
- Simultaneous events:
  - rx_valid in the same cycle as the final write strobe cannot occur (the final byte is already counted).
  - rx_valid in the transition cycle into BOOT is ignored.

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- When defined:
  - Extra outputs csum[15:0], tx_valid (1), tx_data[7:0], plus input tx_busy (1).
  - csum is the 16-bit wraparound sum of all bytes accepted in LOAD, reset 0.
  - After the final write and before cpu_rstb rises, the block sends csum[7:0] then csum[15:8] over the UART transmitter. For each byte, tx_valid is pulsed for 1 cycle only when tx_busy=0; the block then waits for tx_busy to rise and fall before sending the next byte.
  - This adds FSM state ACK between LOAD and BOOT.
- When undefined: no extra ports; LOAD goes directly to BOOT.

Decomposition:
- Package uart_boot_pkg holds:
  - the state enum typedef (SAMPLE, LOAD, ACK, BOOT);
  - BYTES_PER_WORD=4;
  - the localparam for csum width.
- One sub-module is natural: uart_byte_packer (byte-lane shift and word-valid strobe), instantiated once.

Test Plan:
- sw_uart_upgrade_b=1 at reset release -> cpu_rstb=1 two cycles after rstb rises; ram_wr_en never asserts; load_done=0.
- RAM_SIZE=16, upgrade mode, bytes 00..0F at baudrate_cfg 6 -> four writes: addr0=0x03020100, addr1=0x07060504, addr2=0x0B0A0908, addr3=0x0F0E0D0C; then load_done=1, cpu_rstb=1.
- Back-to-back rx_valid pulses on consecutive cycles for bytes AA,BB,CC,DD,EE -> write 0xDDCCBBAA at cycle after DD; EE held in lane 0; no write until 3 more bytes.
- Reset asserted after 6 bytes, then full 16-byte reload of 10..1F -> first write addr0=0x13121110; no stale data.
- Extra 5 bytes sent after load_done -> no ram_wr_en, ram_addr unchanged.
- With UART_LOADER_CHECKSUM_EN, bytes 00..0F -> csum=0x0078; tx bytes 0x78 then 0x00 are sent, and cpu_rstb rises only after the second tx_busy falls.
